cell_bram_read_arbiter: RTL and testbench

//  Shares the 4-bank port-A read interface of the HOG cell-histogram BRAM among NUM_REQ requesters.

---
 rtl/hog_pkg.sv | 15 +
 rtl/cell_arb_rr_picker.sv | 48 ++++
 rtl/cell_bram_read_arbiter.sv | 132 +++++++++++++
 tb/tb_cell_bram_read_arbiter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/hog_pkg.sv
// Shared constants for the HOG cell-histogram BRAM read path.
// Latency: n/a (package only).
// Backpressure: n/a.
package hog_pkg;
    localparam int CELL_BANKS = 4;

    localparam int REQ_NORM = 0;
    localparam int REQ_PCA  = 1;
    localparam int REQ_HAM  = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;
endpackage

// File: rtl/cell_arb_rr_picker.sv
// Picks one requester: round-robin from ptr, or lowest index under CELL_ARB_FIXED_PRIO_EN.
// Latency: combinational.
// Backpressure: none; winner is all-zero when no request is pending.
module cell_arb_rr_picker #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] winner,
    output logic [IDX_W-1:0]   idx
);
`ifdef CELL_ARB_FIXED_PRIO_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr;

    // Scan high to low so the lowest pending index is the last one written.
    always_comb begin
        winner = '0;
        idx    = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                winner    = '0;
                winner[i] = 1'b1;
                idx       = IDX_W'(i);
            end
        end
    end
`else
    logic [IDX_W-1:0] cand;
    logic             found;

    always_comb begin
        winner = '0;
        idx    = '0;
        found  = 1'b0;
        cand   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = IDX_W'((int'(ptr) + i) % NUM_REQ);
            if (!found && req[cand]) begin
                found        = 1'b1;
                winner[cand] = 1'b1;
                idx          = cand;
            end
        end
    end
`endif
endmodule

// File: rtl/cell_bram_read_arbiter.sv
// Shares the 4-bank histogram BRAM read port among NUM_REQ requesters; optional CELL_ARB_FIXED_PRIO_EN.
// Latency: grant one cycle after request; rvalid RD_LAT cycles after each address beat.
// Backpressure: a requester issues only while granted; bursts bounded by MAX_BURST unless locked.
module cell_bram_read_arbiter
    import hog_pkg::*;
#(
    parameter int NUM_REQ   = 3,
    parameter int ADDR_W    = 13,
    parameter int DATA_W    = 35,
    parameter int RD_LAT    = 2,
    parameter int MAX_BURST = 16
) (
    input  logic                                aclk,
    input  logic                                arest_n,
    input  logic                                rd_enable,
    input  logic [NUM_REQ-1:0]                  req,
    input  logic [NUM_REQ-1:0]                  lock,
    input  logic [NUM_REQ*CELL_BANKS*ADDR_W-1:0] addr,
    output logic [NUM_REQ-1:0]                  gnt,
    output logic [NUM_REQ-1:0]                  rvalid,
    output logic [CELL_BANKS*DATA_W-1:0]        rdata,
    output logic [CELL_BANKS*ADDR_W-1:0]        bram_addr,
    input  logic [CELL_BANKS*DATA_W-1:0]        bram_dout,
    output logic                                busy
);
    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W  = $clog2(MAX_BURST + 1);
    localparam int BEAT_W = CELL_BANKS * ADDR_W;

    arb_state_t         state;
    logic [IDX_W-1:0]   owner;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   pick_idx;
    logic [NUM_REQ-1:0] pick_oh;
    logic [CNT_W-1:0]   beat_cnt;
    logic               beat;
    logic               other_pending;
    logic               burst_done;
    logic               release_gnt;
    logic [RD_LAT-1:0]  pipe_vld;
    logic [IDX_W-1:0]   pipe_idx [RD_LAT];

    cell_arb_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req     (req),
        .ptr     (ptr),
        .winner  (pick_oh),
        .idx     (pick_idx)
    );

    assign beat = (state == ST_GRANT) && req[owner] && rd_enable;

`ifdef CELL_ARB_FIXED_PRIO_EN
    // gnt is one-hot in GRANT, so gnt-1 masks exactly the lower-index requesters.
    assign other_pending = |(req & (gnt - NUM_REQ'(1)));
`else
    assign other_pending = |(req & ~gnt);
`endif

    // >= so a counter saturated during an uncontended run still yields once someone waits.
    assign burst_done  = beat && (beat_cnt >= CNT_W'(MAX_BURST - 1)) &&
                         !lock[owner] && other_pending;
    assign release_gnt = !rd_enable || !req[owner] || burst_done;

    always_comb begin
        bram_addr = '0;
        if (beat) begin
            bram_addr = addr[int'(owner)*BEAT_W +: BEAT_W];
        end
    end

    always_ff @(posedge aclk or negedge arest_n) begin
        if (!arest_n) begin
            state    <= ST_IDLE;
            owner    <= '0;
            ptr      <= '0;
            beat_cnt <= '0;
            gnt      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rd_enable && |req) begin
                        owner    <= pick_idx;
                        gnt      <= pick_oh;
                        ptr      <= (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
                        beat_cnt <= '0;
                        state    <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (beat && beat_cnt != CNT_W'(MAX_BURST)) begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                    if (release_gnt) begin
                        gnt   <= '0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Return pipe tracks which requester each in-flight read belongs to.
    always_ff @(posedge aclk or negedge arest_n) begin
        if (!arest_n) begin
            pipe_vld <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_idx[i] <= '0;
            end
        end else begin
            pipe_vld[0] <= beat;
            pipe_idx[0] <= owner;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_idx[i] <= pipe_idx[i-1];
            end
        end
    end

    always_comb begin
        rvalid = '0;
        if (pipe_vld[RD_LAT-1]) begin
            rvalid[pipe_idx[RD_LAT-1]] = 1'b1;
        end
    end

    assign rdata = bram_dout;
    assign busy  = (state == ST_GRANT) || (|pipe_vld);
endmodule

// File: tb/tb_cell_bram_read_arbiter.sv
// Self-checking bench for cell_bram_read_arbiter with a behavioural BRAM and a return scoreboard.
module tb_cell_bram_read_arbiter;
    localparam int NR  = 3;
    localparam int AW  = 13;
    localparam int DW  = 35;
    localparam int LAT = 2;
    localparam int MB  = 16;
    localparam int NB  = 4;

    typedef struct {
        int             idx;
        logic [NB*DW-1:0] data;
        int             due;
    } exp_t;

    logic                   aclk = 1'b0;
    logic                   arest_n;
    logic                   rd_enable;
    logic [NR-1:0]          req;
    logic [NR-1:0]          lock;
    logic [NR*NB*AW-1:0]    addr;
    logic [NR-1:0]          gnt;
    logic [NR-1:0]          rvalid;
    logic [NB*DW-1:0]       rdata;
    logic [NB*AW-1:0]       bram_addr;
    logic [NB*DW-1:0]       bram_dout;
    logic                   busy;

    int   checks = 0;
    int   passes = 0;
    int   cyc    = 0;
    exp_t sb[$];
    exp_t mon_e;
    logic [NR-1:0] mon_rv;

    cell_bram_read_arbiter #(
        .NUM_REQ   (NR),
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .RD_LAT    (LAT),
        .MAX_BURST (MB)
    ) dut (
        .aclk      (aclk),
        .arest_n   (arest_n),
        .rd_enable (rd_enable),
        .req       (req),
        .lock      (lock),
        .addr      (addr),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .bram_addr (bram_addr),
        .bram_dout (bram_dout),
        .busy      (busy)
    );

    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] mem_word(input int b, input logic [AW-1:0] a);
        return {a, 2'(b), a, 7'(b + 3)};
    endfunction

    function automatic logic [AW-1:0] addr_of(input int i, input int b, input int c);
        return AW'((i << 10) | (b << 8) | (c & 255));
    endfunction

    // Behavioural BRAM: address in cycle t, data out in cycle t+LAT.
    logic [NB*AW-1:0] dl [LAT];
    initial for (int i = 0; i < LAT; i++) dl[i] = '0;
    always @(posedge aclk) begin
        dl[0] <= bram_addr;
        for (int i = 1; i < LAT; i++) dl[i] <= dl[i-1];
    end
    always @* begin
        for (int b = 0; b < NB; b++) begin
            bram_dout[b*DW +: DW] = mem_word(b, dl[LAT-1][b*AW +: AW]);
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Drive one cycle of inputs, check gnt/bram_addr, and enqueue the expected return.
    task automatic step(input logic [NR-1:0] r, input logic [NR-1:0] l, input logic en,
                        input logic [NR-1:0] eg);
        int               c;
        int               o;
        logic             bt;
        logic [NB*AW-1:0] eba;
        exp_t             e;
        c = cyc;
        req = r;
        lock = l;
        rd_enable = en;
        for (int i = 0; i < NR; i++)
            for (int b = 0; b < NB; b++)
                addr[(i*NB + b)*AW +: AW] = addr_of(i, b, c);
        @(negedge aclk);
        chk("gnt", 64'(gnt), 64'(eg));
        o = 0;
        for (int i = 0; i < NR; i++) if (eg[i]) o = i;
        bt  = (eg != '0) && ((r & eg) != '0) && en;
        eba = '0;
        if (bt) begin
            e.idx = o;
            e.due = c + LAT;
            for (int b = 0; b < NB; b++) begin
                eba[b*AW +: AW]   = addr_of(o, b, c);
                e.data[b*DW +: DW] = mem_word(b, addr_of(o, b, c));
            end
            sb.push_back(e);
        end
        chk("bram_addr", 64'(bram_addr), 64'(eba));
        if (eg != '0) chk("busy_in_grant", 64'(busy), 64'd1);
        @(posedge aclk);
        #1;
    endtask

    // Return-path monitor: every rvalid must match the head of the scoreboard, on time.
    always @(negedge aclk) begin
        if (arest_n) begin
            if (rvalid != '0) begin
                checks++;
                if (sb.size() == 0) begin
                    $display("FAIL unexpected_rvalid: rvalid=%b with no read outstanding (cycle %0d)", rvalid, cyc);
                end else begin
                    mon_e  = sb.pop_front();
                    mon_rv = NR'(1) << mon_e.idx;
                    if (rvalid == mon_rv && rdata == mon_e.data && cyc == mon_e.due) passes++;
                    else $display("FAIL rvalid_return: rvalid=%b rdata=%h cycle=%0d, expected rvalid=%b rdata=%h cycle=%0d",
                                  rvalid, rdata, cyc, mon_rv, mon_e.data, mon_e.due);
                end
            end else if (sb.size() > 0 && sb[0].due <= cyc) begin
                checks++;
                mon_e = sb.pop_front();
                $display("FAIL missing_rvalid: rvalid=0 at cycle %0d, expected requester %0d by cycle %0d",
                         cyc, mon_e.idx, mon_e.due);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        arest_n = 1'b0;
        rd_enable = 1'b0;
        req = '0;
        lock = '0;
        addr = '0;
        repeat (3) @(posedge aclk);
        #1;
        chk("reset_gnt", 64'(gnt), 64'd0);
        chk("reset_rvalid", 64'(rvalid), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_bram_addr", 64'(bram_addr), 64'd0);
        arest_n = 1'b1;

        // Single requester: grant next cycle, three beats, release when req drops.
        step(3'b001, 3'b000, 1'b1, 3'b000);
        repeat (3) step(3'b001, 3'b000, 1'b1, 3'b001);
        step(3'b000, 3'b000, 1'b1, 3'b001);
        step(3'b000, 3'b000, 1'b1, 3'b000);

`ifdef CELL_ARB_FIXED_PRIO_EN
        // Owner 1 yields after 16 beats only once lower-index requester 0 waits.
        step(3'b110, 3'b000, 1'b1, 3'b000);
        repeat (5)  step(3'b110, 3'b000, 1'b1, 3'b010);
        repeat (11) step(3'b111, 3'b000, 1'b1, 3'b010);
        step(3'b111, 3'b000, 1'b1, 3'b000);
        repeat (2)  step(3'b111, 3'b000, 1'b1, 3'b001);
        step(3'b000, 3'b000, 1'b1, 3'b001);
        step(3'b000, 3'b000, 1'b1, 3'b000);
`else
        // All requesting, no lock: ptr is 1, so grants go 1 -> 2 -> 0, 16 beats each, one idle gap.
        step(3'b111, 3'b000, 1'b1, 3'b000);
        repeat (MB) step(3'b111, 3'b000, 1'b1, 3'b010);
        step(3'b111, 3'b000, 1'b1, 3'b000);
        repeat (MB) step(3'b111, 3'b000, 1'b1, 3'b100);
        step(3'b111, 3'b000, 1'b1, 3'b000);
        repeat (MB) step(3'b111, 3'b000, 1'b1, 3'b001);
        step(3'b000, 3'b000, 1'b1, 3'b000);

        // Locked requester 1 keeps the grant past 16 beats; then ptr=2 hands it to requester 2.
        step(3'b011, 3'b010, 1'b1, 3'b000);
        repeat (20) step(3'b011, 3'b010, 1'b1, 3'b010);
        step(3'b101, 3'b000, 1'b1, 3'b010);
        step(3'b101, 3'b000, 1'b1, 3'b000);

        // rd_enable falls mid-burst: grant drops, two outstanding reads still return.
        repeat (4) step(3'b101, 3'b000, 1'b1, 3'b100);
        step(3'b101, 3'b000, 1'b0, 3'b100);
        repeat (4) step(3'b101, 3'b000, 1'b0, 3'b000);
        chk("busy_after_drain", 64'(busy), 64'd0);
        step(3'b000, 3'b000, 1'b1, 3'b000);
`endif

        // Reset with reads in flight: outputs clear at once, no stale rvalid afterwards.
        step(3'b001, 3'b000, 1'b1, 3'b000);
        repeat (3) step(3'b001, 3'b000, 1'b1, 3'b001);
        arest_n = 1'b0;
        sb.delete();
        #1;
        chk("midreset_gnt", 64'(gnt), 64'd0);
        chk("midreset_rvalid", 64'(rvalid), 64'd0);
        chk("midreset_busy", 64'(busy), 64'd0);
        chk("midreset_bram_addr", 64'(bram_addr), 64'd0);
        req = '0;
        @(posedge aclk);
        #1;
        arest_n = 1'b1;
        repeat (4) step(3'b000, 3'b000, 1'b1, 3'b000);
        chk("post_reset_busy", 64'(busy), 64'd0);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
